// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbitration blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_XMIT = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_t;

    localparam int DBIT_DEF = 8;

    // Index width for n requesters, never narrower than one bit.
    function automatic int gw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Hold counter width; a disabled timeout still gets a one-bit counter.
    function automatic int hold_cw(input int to);
        return (to > 0) ? $clog2(to + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is set.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]     req,
    input  logic [gw(NREQ)-1:0] ptr,
    output logic                any,
    output logic [gw(NREQ)-1:0] idx
);

    localparam int GW = gw(NREQ);

    logic [GW:0]   w_sum;
    logic [GW-1:0] w_cand;

    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        any    = |req;
        idx    = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (GW+1)'(k);
            if (w_sum >= (GW+1)'(NREQ)) begin
                w_sum = w_sum - (GW+1)'(NREQ);
            end
            w_cand = w_sum[GW-1:0];
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte producers, with packet lock.
// Latency: accept at T, tx_start at T+1; next accept no earlier than the cycle after tx_done_tick.
// Backpressure: req_ready pulses only when the transmitter is free; requesters hold valid/data until then.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DBIT    = DBIT_DEF,
    parameter int HOLD_TO = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DBIT-1:0] req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic [gw(NREQ)-1:0]  grant_id,
    output logic                 busy,
    output logic                 lock_abort
);

    localparam int GW = gw(NREQ);
    localparam int CW = hold_cw(HOLD_TO);
    localparam logic [CW-1:0] HOLD_LAST = (HOLD_TO > 0) ? CW'(HOLD_TO - 1) : '0;

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic [GW-1:0] r_ptr;
    logic [GW-1:0] r_grant;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic [DBIT-1:0] r_din;

    logic            w_pick_any;
    logic [GW-1:0]   w_pick_idx;
    logic            w_accept;
    logic [GW-1:0]   w_idx;
    logic            w_release;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic [DBIT-1:0] w_dat;
    logic            w_lst;

    uart_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .any (w_pick_any),
        .idx (w_pick_idx)
    );

    // Next-state decode plus the combinational accept/abort strobes.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_idx      = r_grant;
        w_release  = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        lock_abort = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_accept = 1'b1;
                    w_idx    = w_pick_idx;
                    w_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next = ST_XMIT;
            end
            ST_XMIT: begin
                if (tx_done_tick) begin
                    if (r_last) begin
                        w_release = 1'b1;
                        w_next    = ST_IDLE;
                    end else begin
                        w_cnt_clr = 1'b1;
                        w_next    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Locked: only the current owner may continue its packet.
                if (req_valid[r_grant]) begin
                    w_accept = 1'b1;
                    w_next   = ST_LOAD;
                end else if ((HOLD_TO != 0) && (r_cnt == HOLD_LAST)) begin
                    lock_abort = 1'b1;
                    w_release  = 1'b1;
                    w_next     = ST_IDLE;
                end else if (HOLD_TO != 0) begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output decode and selection of the accepted requester's byte.
    always_comb begin
        req_ready = '0;
        w_dat     = '0;
        w_lst     = 1'b0;
        if (w_accept) begin
            req_ready[w_idx] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == GW'(i)) begin
                w_dat = req_data[i*DBIT +: DBIT];
                w_lst = req_last[i];
            end
        end
    end

    assign tx_start = (r_state == ST_LOAD);
    assign busy     = w_accept | (r_state == ST_LOAD) | (r_state == ST_XMIT);
    assign tx_din   = r_din;
    assign grant_id = r_grant;

    // State, grant, pointer, latched byte and hold counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_grant <= w_idx;
                r_din   <= w_dat;
                r_last  <= w_lst;
            end
            // Pointer moves only when a packet is released, never per byte.
            if (w_release) begin
                r_ptr <= (r_grant == GW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed requester traffic, uart_tx done model, scoreboard monitor.
// Latency: done model answers DONE_LAT cycles after each tx_start.
// Backpressure: requester queues hold each byte until its req_ready pulse.
module tb_uart_tx_arbiter;

    localparam int NREQ     = 4;
    localparam int DBIT     = 8;
    localparam int HOLD_TO  = 8;
    localparam int GW       = 2;
    localparam int DONE_LAT = 4;

    typedef struct {
        logic [DBIT-1:0] data;
        logic            last;
        int              gap;
    } ent_t;

    typedef struct {
        logic [GW-1:0]   id;
        logic [DBIT-1:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_din;
    logic                 tx_done_tick;
    logic [GW-1:0]        grant_id;
    logic                 busy;
    logic                 lock_abort;

    logic man_done = 1'b0;
    logic model_done = 1'b0;
    assign tx_done_tick = man_done | model_done;

    ent_t rq[NREQ][$];
    exp_t sb[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_done = 0;
    int abort_cnt = 0;
    int abort_dist = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DBIT    (DBIT),
        .HOLD_TO (HOLD_TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .grant_id     (grant_id),
        .busy         (busy),
        .lock_abort   (lock_abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic put(input int r, input logic [DBIT-1:0] d, input logic last, input int gap);
        ent_t e;
        e.data = d;
        e.last = last;
        e.gap  = gap;
        rq[r].push_back(e);
    endtask

    task automatic exp_tx(input int id, input logic [DBIT-1:0] d);
        exp_t e;
        e.id   = GW'(id);
        e.data = d;
        sb.push_back(e);
    endtask

    function automatic bit all_empty();
        bit r;
        r = (sb.size() == 0);
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_quiet(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (all_empty() && !busy && !tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_completes"}, 32'(ok), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_start_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"},  32'(req_ready),  32'd0);
        check({name, "_tx_start"},   32'(tx_start),   32'd0);
        check({name, "_tx_din"},     32'(tx_din),     32'd0);
        check({name, "_grant_id"},   32'(grant_id),   32'd0);
        check({name, "_busy"},       32'(busy),       32'd0);
        check({name, "_lock_abort"}, 32'(lock_abort), 32'd0);
    endtask

    // Requester model: presents queue heads, pops on the sampled req_ready pulse.
    initial begin
        int gapc[NREQ];
        logic [NREQ-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NREQ; i++) gapc[i] = 0;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && rq[i].size() != 0) begin
                    void'(rq[i].pop_front());
                    gapc[i] = 0;
                end
                if (rq[i].size() != 0 && gapc[i] < rq[i][0].gap) gapc[i]++;
                if (rq[i].size() != 0 && gapc[i] >= rq[i][0].gap) begin
                    req_valid[i]               = 1'b1;
                    req_data[i*DBIT +: DBIT]   = rq[i][0].data;
                    req_last[i]                = rq[i][0].last;
                end else begin
                    req_valid[i]               = 1'b0;
                    req_data[i*DBIT +: DBIT]   = '0;
                    req_last[i]                = 1'b0;
                end
            end
        end
    end

    // uart_tx stand-in: done tick DONE_LAT cycles after each start.
    initial begin
        int  cnt;
        bit  act;
        cnt = 0;
        act = 1'b0;
        forever begin
            @(posedge clk); #1;
            model_done = 1'b0;
            if (!reset_n) begin
                act = 1'b0;
            end else if (act) begin
                cnt++;
                if (cnt == DONE_LAT) begin
                    model_done = 1'b1;
                    act = 1'b0;
                end
            end else if (tx_start) begin
                act = 1'b1;
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every tx_start and checks handshake timing.
    initial begin
        logic [NREQ-1:0] prev_rdy;
        logic [DBIT-1:0] cur_din;
        bit              infl;
        exp_t            e;
        prev_rdy = '0;
        cur_din  = '0;
        infl     = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                infl     = 1'b0;
                prev_rdy = '0;
            end else begin
                if (req_ready != '0) begin
                    check("rdy_onehot", 32'($onehot(req_ready)), 32'd1);
                    check("rdy_while_inflight", 32'(infl), 32'd0);
                    check("busy_at_accept", 32'(busy), 32'd1);
                end
                if (infl) begin
                    check("busy_inflight", 32'(busy), 32'd1);
                    check("tx_din_stable", 32'(tx_din), 32'(cur_din));
                end
                if (tx_start) begin
                    check("start_follows_rdy", 32'(prev_rdy != '0), 32'd1);
                    check("start_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("grant_id", 32'(grant_id), 32'(e.id));
                        check("tx_din", 32'(tx_din), 32'(e.data));
                        check("rdy_bit_matches", 32'(prev_rdy), 32'(1 << e.id));
                    end
                    cur_din = tx_din;
                    infl    = 1'b1;
                end else if (infl && tx_done_tick) begin
                    infl      = 1'b0;
                    last_done = cyc;
                end
                if (lock_abort) begin
                    abort_cnt++;
                    abort_dist = cyc - last_done;
                end
                prev_rdy = req_ready;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) reset_n = 1'b1;

        // Single requester: 2 sends 0xA5 as a one-byte packet
        @(negedge clk);
        put(2, 8'hA5, 1'b1, 0);
        exp_tx(2, 8'hA5);
        wait_quiet("single");
        check("single_busy_low", 32'(busy), 32'd0);
        check("single_grant_id", 32'(grant_id), 32'd2);

        // Round-robin from reset: 0,1,2,3,0
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        put(0, 8'h10, 1'b1, 0);
        put(0, 8'h11, 1'b1, 0);
        put(1, 8'h20, 1'b1, 0);
        put(2, 8'h30, 1'b1, 0);
        put(3, 8'h40, 1'b1, 0);
        exp_tx(0, 8'h10);
        exp_tx(1, 8'h20);
        exp_tx(2, 8'h30);
        exp_tx(3, 8'h40);
        exp_tx(0, 8'h11);
        wait_quiet("rr");
        check("rr_grant_id", 32'(grant_id), 32'd0);

        // Packet lock (ptr=1): requester 1 pauses between bytes, 0 waits throughout
        @(negedge clk);
        put(0, 8'h55, 1'b1, 0);
        put(1, 8'hB1, 1'b0, 0);
        put(1, 8'hB2, 1'b0, 3);
        put(1, 8'hB3, 1'b1, 3);
        exp_tx(1, 8'hB1);
        exp_tx(1, 8'hB2);
        exp_tx(1, 8'hB3);
        exp_tx(0, 8'h55);
        wait_quiet("lock");
        check("lock_no_abort", 32'(abort_cnt), 32'd0);

        // Timeout (ptr=1): requester 3 stalls mid-packet, lock breaks, ptr -> 0
        @(negedge clk);
        put(3, 8'hC3, 1'b0, 0);
        put(0, 8'h0D, 1'b1, 10);
        put(1, 8'h1D, 1'b1, 10);
        exp_tx(3, 8'hC3);
        exp_tx(0, 8'h0D);
        exp_tx(1, 8'h1D);
        wait_quiet("timeout");
        check("timeout_abort_count", 32'(abort_cnt), 32'd1);
        check("timeout_abort_delay", 32'(abort_dist), 32'd8);

        // Spurious done in IDLE (ptr=2)
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        check("spur_idle_ready", 32'(req_ready), 32'd0);
        check("spur_idle_start", 32'(tx_start), 32'd0);
        check("spur_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("spur_idle_start2", 32'(tx_start), 32'd0);

        // Spurious done in LOAD: transfer must still wait for the real done
        @(negedge clk);
        put(2, 8'hE1, 1'b1, 0);
        put(1, 8'hE2, 1'b1, 0);
        exp_tx(2, 8'hE1);
        exp_tx(1, 8'hE2);
        wait_start("spur_load");
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        check("spur_load_busy", 32'(busy), 32'd1);
        check("spur_load_ready", 32'(req_ready), 32'd0);
        wait_quiet("spur_load");

        // Reset mid-XMIT (ptr=2 before reset)
        @(negedge clk);
        put(0, 8'h77, 1'b1, 0);
        exp_tx(0, 8'h77);
        wait_start("rst");
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst_mid_xmit");
        check("rst_sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        put(2, 8'h02, 1'b1, 0);
        put(0, 8'h01, 1'b1, 0);
        exp_tx(0, 8'h01);
        exp_tx(2, 8'h02);
        wait_quiet("rst_restart");
        check("final_abort_count", 32'(abort_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
